// File: rtl/phase_pattern_gen.sv
// Phase pattern generator: NCO-driven reference square wave plus a copy
// lagging by a programmable phase. Each clock it emits four sub-samples per
// stream for a x4 serializer (bit 3 leaves first). Frequency/phase updates
// are staged in a shadow register and, while running, committed only on a
// reference period boundary so no runt pulse is ever produced.
module phase_pattern_gen #(
  parameter int ACC_BITS   = 32,
  parameter int COUNT_BITS = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_ce,
  input  logic                  i_enable,
  input  logic [ACC_BITS-1:0]   i_freq_word,
  input  logic [ACC_BITS-1:0]   i_phase_word,
  input  logic                  i_load,
  output logic                  o_load_ready,
  output logic [3:0]            o_out_ref,
  output logic [3:0]            o_out_shifted,
  output logic [COUNT_BITS-1:0] o_ref_edge_count
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN      = 2'd1,
    S_RUN_PEND = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;

  logic [ACC_BITS-1:0]   r_acc;
  logic [ACC_BITS-1:0]   r_f_act;
  logic [ACC_BITS-1:0]   r_p_act;
  logic [ACC_BITS-1:0]   r_shadow_f;
  logic [ACC_BITS-1:0]   r_shadow_p;
  logic [3:0]            r_out_ref;
  logic [3:0]            r_out_shifted;
  logic                  r_load_ready;
  logic                  r_last_bit;
  logic [COUNT_BITS-1:0] r_count;

  logic [ACC_BITS-1:0]   w_acc_next;
  logic [ACC_BITS-1:0]   w_f_act_next;
  logic [ACC_BITS-1:0]   w_p_act_next;
  logic [ACC_BITS-1:0]   w_shadow_f_next;
  logic [ACC_BITS-1:0]   w_shadow_p_next;
  logic [3:0]            w_out_ref_next;
  logic [3:0]            w_out_shifted_next;
  logic                  w_load_ready_next;
  logic                  w_last_bit_next;
  logic [COUNT_BITS-1:0] w_count_next;

  logic [ACC_BITS-1:0]   w_a0;
  logic [ACC_BITS-1:0]   w_a1;
  logic [ACC_BITS-1:0]   w_a2;
  logic [ACC_BITS-1:0]   w_a3;
  logic [ACC_BITS-1:0]   w_d0;
  logic [ACC_BITS-1:0]   w_d1;
  logic [ACC_BITS-1:0]   w_d2;
  logic [ACC_BITS-1:0]   w_d3;
  logic [3:0]            w_ref_word;
  logic [3:0]            w_sh_word;
  logic [ACC_BITS+2:0]   w_sum;
  logic                  w_wrap;
  logic [2:0]            w_edges;
  logic                  w_accept;

  // The four sub-sample phases of this clock; the shifted stream subtracts
  // the lag so it trails the reference by exactly p_act of a period.
  assign w_a0 = r_acc;
  assign w_a1 = r_acc + r_f_act;
  assign w_a2 = r_acc + (r_f_act << 1);
  assign w_a3 = r_acc + r_f_act + (r_f_act << 1);
  assign w_d0 = w_a0 - r_p_act;
  assign w_d1 = w_a1 - r_p_act;
  assign w_d2 = w_a2 - r_p_act;
  assign w_d3 = w_a3 - r_p_act;

  assign w_ref_word = {w_a0[ACC_BITS-1], w_a1[ACC_BITS-1], w_a2[ACC_BITS-1], w_a3[ACC_BITS-1]};
  assign w_sh_word  = {w_d0[ACC_BITS-1], w_d1[ACC_BITS-1], w_d2[ACC_BITS-1], w_d3[ACC_BITS-1]};

  // Widened sum so any carry past the accumulator marks a period boundary,
  // even for aliasing frequency words where 4*f exceeds one period.
  assign w_sum  = {3'b000, r_acc} + {1'b0, r_f_act, 2'b00};
  assign w_wrap = |w_sum[ACC_BITS+2:ACC_BITS];

  // Rising edges across the previous clock's last bit and this word.
  assign w_edges = {2'b00, ~r_last_bit    & w_ref_word[3]}
                 + {2'b00, ~w_ref_word[3] & w_ref_word[2]}
                 + {2'b00, ~w_ref_word[2] & w_ref_word[1]}
                 + {2'b00, ~w_ref_word[1] & w_ref_word[0]};

  assign w_accept = i_load & r_load_ready;

  // Next-state and datapath update; everything holds when the clock enable is low.
  always_comb begin
    w_state_next       = r_state;
    w_acc_next         = r_acc;
    w_f_act_next       = r_f_act;
    w_p_act_next       = r_p_act;
    w_shadow_f_next    = r_shadow_f;
    w_shadow_p_next    = r_shadow_p;
    w_out_ref_next     = r_out_ref;
    w_out_shifted_next = r_out_shifted;
    w_load_ready_next  = r_load_ready;
    w_last_bit_next    = r_last_bit;
    w_count_next       = r_count;

    if (i_ce) begin
      if (!i_enable) begin
        w_state_next       = S_IDLE;
        w_acc_next         = '0;
        w_out_ref_next     = 4'h0;
        w_out_shifted_next = 4'h0;
        w_last_bit_next    = 1'b0;
        if (!r_load_ready) begin
          w_f_act_next      = r_shadow_f;
          w_p_act_next      = r_shadow_p;
          w_load_ready_next = 1'b1;
        end
        if (w_accept) begin
          w_shadow_f_next   = i_freq_word;
          w_shadow_p_next   = i_phase_word;
          w_load_ready_next = 1'b0;
        end
      end else begin
        w_acc_next         = w_sum[ACC_BITS-1:0];
        w_out_ref_next     = w_ref_word;
        w_out_shifted_next = w_sh_word;
        w_last_bit_next    = w_ref_word[0];
        w_count_next       = r_count + {{(COUNT_BITS-3){1'b0}}, w_edges};
        case (r_state)
          S_IDLE: begin
            if (!r_load_ready) begin
              w_f_act_next      = r_shadow_f;
              w_p_act_next      = r_shadow_p;
              w_load_ready_next = 1'b1;
              w_state_next      = S_RUN;
            end else if (w_accept) begin
              w_shadow_f_next   = i_freq_word;
              w_shadow_p_next   = i_phase_word;
              w_load_ready_next = 1'b0;
              w_state_next      = S_RUN_PEND;
            end else begin
              w_state_next      = S_RUN;
            end
          end
          S_RUN: begin
            if (w_accept) begin
              w_shadow_f_next   = i_freq_word;
              w_shadow_p_next   = i_phase_word;
              w_load_ready_next = 1'b0;
              w_state_next      = S_RUN_PEND;
            end
          end
          S_RUN_PEND: begin
            if (w_wrap || (r_f_act == '0)) begin
              w_f_act_next      = r_shadow_f;
              w_p_act_next      = r_shadow_p;
              w_load_ready_next = 1'b1;
              w_state_next      = S_RUN;
            end
          end
          default: begin
            w_state_next = S_IDLE;
          end
        endcase
      end
    end
  end

  // State and datapath registers, cleared asynchronously by reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_acc         <= '0;
      r_f_act       <= '0;
      r_p_act       <= '0;
      r_shadow_f    <= '0;
      r_shadow_p    <= '0;
      r_out_ref     <= 4'h0;
      r_out_shifted <= 4'h0;
      r_load_ready  <= 1'b1;
      r_last_bit    <= 1'b0;
      r_count       <= '0;
    end else begin
      r_state       <= w_state_next;
      r_acc         <= w_acc_next;
      r_f_act       <= w_f_act_next;
      r_p_act       <= w_p_act_next;
      r_shadow_f    <= w_shadow_f_next;
      r_shadow_p    <= w_shadow_p_next;
      r_out_ref     <= w_out_ref_next;
      r_out_shifted <= w_out_shifted_next;
      r_load_ready  <= w_load_ready_next;
      r_last_bit    <= w_last_bit_next;
      r_count       <= w_count_next;
    end
  end

  assign o_load_ready     = r_load_ready;
  assign o_out_ref        = r_out_ref;
  assign o_out_shifted    = r_out_shifted;
  assign o_ref_edge_count = r_count;

endmodule

// File: tb/tb_phase_pattern_gen.sv
// Directed bench for phase_pattern_gen with hand-computed word sequences.
module tb_phase_pattern_gen;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        ce     = 1'b0;
  logic        enable = 1'b0;
  logic        load   = 1'b0;
  logic [31:0] freq   = 32'h0;
  logic [31:0] phase  = 32'h0;
  logic        ready;
  logic [3:0]  oref;
  logic [3:0]  osh;
  logic [15:0] cnt;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [15:0] expCnt      = 16'h0;
  logic [3:0]  eR;
  logic [3:0]  eS;

  phase_pattern_gen #(.ACC_BITS(32), .COUNT_BITS(16)) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_ce             (ce),
    .i_enable         (enable),
    .i_freq_word      (freq),
    .i_phase_word     (phase),
    .i_load           (load),
    .o_load_ready     (ready),
    .o_out_ref        (oref),
    .o_out_shifted    (osh),
    .o_ref_edge_count (cnt)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ce = 1'b1; enable = 1'b0; load = 1'b0;
    #12;
    vectors++;
    if ({oref, osh, ready, cnt} !== {4'h0, 4'h0, 1'b1, 16'h0}) begin
      $display("[TB] FAIL reset_hold: got ref=%h sh=%h rdy=%b cnt=%0d, expected 0 0 1 0", oref, osh, ready, cnt);
      miscompares++;
    end
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    vectors++;
    if ({oref, osh, ready, cnt} !== {4'h0, 4'h0, 1'b1, 16'h0}) begin
      $display("[TB] FAIL reset_idle: got ref=%h sh=%h rdy=%b cnt=%0d, expected 0 0 1 0", oref, osh, ready, cnt);
      miscompares++;
    end
  endtask

  task automatic test_basic();
    freq = 32'h2000_0000; phase = 32'h0; load = 1'b1;
    tick();
    vectors++;
    if ({ready, oref} !== {1'b0, 4'h0}) begin
      $display("[TB] FAIL idle_load_capture: got rdy=%b ref=%h, expected rdy=0 ref=0", ready, oref);
      miscompares++;
    end
    load = 1'b0;
    tick();
    vectors++;
    if (ready !== 1'b1) begin
      $display("[TB] FAIL idle_load_apply: got rdy=%b, expected 1", ready);
      miscompares++;
    end
    enable = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      tick();
      eR = (n % 2 == 1) ? 4'h0 : 4'hF;
      if (eR == 4'hF) expCnt++;
      vectors++;
      if ({oref, osh} !== {eR, eR}) begin
        $display("[TB] FAIL basic_word%0d: got ref=%b sh=%b, expected %b %b", n, oref, osh, eR, eR);
        miscompares++;
      end
      vectors++;
      if (cnt !== expCnt) begin
        $display("[TB] FAIL basic_count%0d: got %0d, expected %0d", n, cnt, expCnt);
        miscompares++;
      end
    end
  endtask

  task automatic test_phase();
    enable = 1'b0; load = 1'b1; freq = 32'h2000_0000; phase = 32'h4000_0000;
    tick();
    vectors++;
    if ({oref, osh, ready, cnt} !== {4'h0, 4'h0, 1'b0, expCnt}) begin
      $display("[TB] FAIL disable_with_load: got ref=%h sh=%h rdy=%b cnt=%0d, expected 0 0 0 %0d", oref, osh, ready, cnt, expCnt);
      miscompares++;
    end
    load = 1'b0;
    tick();
    vectors++;
    if (ready !== 1'b1) begin
      $display("[TB] FAIL idle_apply_after_disable: got rdy=%b, expected 1", ready);
      miscompares++;
    end
    enable = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      tick();
      eR = (n % 2 == 1) ? 4'h0 : 4'hF;
      eS = (n % 2 == 1) ? 4'hC : 4'h3;
      if (eR == 4'hF) expCnt++;
      vectors++;
      if ({oref, osh, cnt} !== {eR, eS, expCnt}) begin
        $display("[TB] FAIL phase_word%0d: got ref=%b sh=%b cnt=%0d, expected %b %b %0d", n, oref, osh, cnt, eR, eS, expCnt);
        miscompares++;
      end
    end
  endtask

  task automatic test_pending_update();
    freq = 32'h1000_0000; phase = 32'h0; load = 1'b1;
    tick();
    vectors++;
    if ({oref, osh, ready} !== {4'h0, 4'hC, 1'b0}) begin
      $display("[TB] FAIL pend_accept: got ref=%b sh=%b rdy=%b, expected 0000 1100 0", oref, osh, ready);
      miscompares++;
    end
    freq = 32'h0800_0000;
    tick();
    expCnt++;
    vectors++;
    if ({oref, osh, ready, cnt} !== {4'hF, 4'h3, 1'b1, expCnt}) begin
      $display("[TB] FAIL pend_wrap_apply: got ref=%b sh=%b rdy=%b cnt=%0d, expected 1111 0011 1 %0d", oref, osh, ready, cnt, expCnt);
      miscompares++;
    end
    load = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      tick();
      eR = (((n - 1) % 4) >= 2) ? 4'hF : 4'h0;
      if (((n - 1) % 4) == 2) expCnt++;
      vectors++;
      if ({oref, osh, cnt} !== {eR, eR, expCnt}) begin
        $display("[TB] FAIL new_period_word%0d: got ref=%b sh=%b cnt=%0d, expected %b %b %0d", n, oref, osh, cnt, eR, eR, expCnt);
        miscompares++;
      end
    end
  endtask

  task automatic test_ce_freeze();
    for (int n = 1; n <= 3; n++) tick();
    expCnt++;
    vectors++;
    if ({oref, cnt} !== {4'hF, expCnt}) begin
      $display("[TB] FAIL pre_freeze: got ref=%b cnt=%0d, expected 1111 %0d", oref, cnt, expCnt);
      miscompares++;
    end
    ce = 1'b0; load = 1'b1; freq = 32'h3000_0000;
    for (int n = 1; n <= 5; n++) begin
      tick();
      vectors++;
      if ({oref, osh, ready, cnt} !== {4'hF, 4'hF, 1'b1, expCnt}) begin
        $display("[TB] FAIL freeze%0d: got ref=%b sh=%b rdy=%b cnt=%0d, expected 1111 1111 1 %0d", n, oref, osh, ready, cnt, expCnt);
        miscompares++;
      end
    end
    ce = 1'b1; load = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      tick();
      eR = (n == 1 || n == 4) ? 4'hF : 4'h0;
      if (n == 4) expCnt++;
      vectors++;
      if ({oref, osh, cnt} !== {eR, eR, expCnt}) begin
        $display("[TB] FAIL resume_word%0d: got ref=%b sh=%b cnt=%0d, expected %b %b %0d", n, oref, osh, cnt, eR, eR, expCnt);
        miscompares++;
      end
    end
  endtask

  task automatic test_enable_restart();
    enable = 1'b0;
    for (int n = 1; n <= 2; n++) begin
      tick();
      vectors++;
      if ({oref, osh, ready, cnt} !== {4'h0, 4'h0, 1'b1, expCnt}) begin
        $display("[TB] FAIL disable%0d: got ref=%b sh=%b rdy=%b cnt=%0d, expected 0 0 1 %0d", n, oref, osh, ready, cnt, expCnt);
        miscompares++;
      end
    end
    enable = 1'b1;
    for (int n = 1; n <= 3; n++) begin
      tick();
      eR = (n == 3) ? 4'hF : 4'h0;
      if (n == 3) expCnt++;
      vectors++;
      if ({oref, cnt} !== {eR, expCnt}) begin
        $display("[TB] FAIL restart_word%0d: got ref=%b cnt=%0d, expected %b %0d", n, oref, cnt, eR, expCnt);
        miscompares++;
      end
    end
  endtask

  task automatic test_reset_midrun();
    freq = 32'h2000_0000; phase = 32'h0; load = 1'b1;
    tick();
    vectors++;
    if ({oref, ready} !== {4'hF, 1'b0}) begin
      $display("[TB] FAIL load_before_reset: got ref=%b rdy=%b, expected 1111 0", oref, ready);
      miscompares++;
    end
    load = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({oref, osh, ready, cnt} !== {4'h0, 4'h0, 1'b1, 16'h0}) begin
      $display("[TB] FAIL async_reset: got ref=%b sh=%b rdy=%b cnt=%0d, expected 0 0 1 0", oref, osh, ready, cnt);
      miscompares++;
    end
    tick();
    rst_n = 1'b1;
    for (int n = 1; n <= 3; n++) begin
      tick();
      vectors++;
      if ({oref, osh, ready, cnt} !== {4'h0, 4'h0, 1'b1, 16'h0}) begin
        $display("[TB] FAIL zero_freq_run%0d: got ref=%b sh=%b rdy=%b cnt=%0d, expected 0 0 1 0", n, oref, osh, ready, cnt);
        miscompares++;
      end
    end
    load = 1'b1;
    tick();
    vectors++;
    if ({oref, ready} !== {4'h0, 1'b0}) begin
      $display("[TB] FAIL zero_freq_accept: got ref=%b rdy=%b, expected 0000 0", oref, ready);
      miscompares++;
    end
    load = 1'b0;
    tick();
    vectors++;
    if ({oref, ready} !== {4'h0, 1'b1}) begin
      $display("[TB] FAIL zero_freq_apply: got ref=%b rdy=%b, expected 0000 1", oref, ready);
      miscompares++;
    end
    tick();
    vectors++;
    if ({oref, cnt} !== {4'h0, 16'h0}) begin
      $display("[TB] FAIL after_zero_word1: got ref=%b cnt=%0d, expected 0000 0", oref, cnt);
      miscompares++;
    end
    tick();
    vectors++;
    if ({oref, osh, cnt} !== {4'hF, 4'hF, 16'h1}) begin
      $display("[TB] FAIL after_zero_word2: got ref=%b sh=%b cnt=%0d, expected 1111 1111 1", oref, osh, cnt);
      miscompares++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_phase();
    test_pending_update();
    test_ce_freeze();
    test_enable_restart();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
